// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_pkg
//  Description : Shared types and constants for the LBP histogram stage.
//                Provides the dump-sequencer state enum and image geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package lbp_pkg;

    localparam int LBP_BINS    = 256;    // one bin per 8-bit LBP code
    localparam int IMG_W       = 128;    // source image width/height
    localparam int IMG_PIX_INT = 15876;  // (IMG_W-2)^2 interior pixels

    typedef enum logic [1:0] {
        ACC   = 2'd0,   // accumulating codes from the engine
        DRAIN = 2'd1,   // single cycle to retire the last S1 entry
        DUMP  = 2'd2,   // streaming bins to the classifier
        DONE  = 2'd3    // all bins sent, parked until reset
    } lbp_state_e;

endpackage : lbp_pkg
`default_nettype wire

// File: rtl/lbp_histogram_if.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_histogram_if
//  Description : Bundle of the LBP code input stream, the finish level and
//                the histogram dump port with its status outputs.
//                slave  : the histogram block
//                master : whoever drives the codes and consumes the dump
//  Revision    : 1.0  initial release
// ============================================================================
interface lbp_histogram_if #(
    parameter int CNT_W = 14,
    parameter int TOT_W = 15
);
    logic             lbp_valid;   // one-cycle pulse, lbp_data is a code
    logic [7:0]       lbp_data;    // LBP code = bin index
    logic             finish;      // level, high = image complete
    logic             hist_valid;  // hist_bin/hist_count valid
    logic             hist_ready;  // consumer accepts
    logic [7:0]       hist_bin;    // bin index
    logic [CNT_W-1:0] hist_count;  // count for hist_bin
    logic             hist_done;   // all bins transferred
    logic [TOT_W-1:0] pix_total;   // codes accumulated this run
    logic             busy;        // run in progress

    modport master (
        output lbp_valid, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_done, pix_total, busy
    );

    modport slave (
        input  lbp_valid, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_done, pix_total, busy
    );
endinterface : lbp_histogram_if
`default_nettype wire

// File: rtl/lbp_hist_bank.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_hist_bank
//  Description : 256 x CNT_W bin storage with a "touched" bitmap. A bin whose
//                touched bit is clear reads as zero, so clearing the bitmap
//                on reset empties the histogram without a clear sweep.
//  Ports       : clk, reset   clock / async active-high reset (bitmap only)
//                i_raddr      combinational read address
//                o_rdata      read data (0 if bin untouched)
//                i_we         write enable, lands at the clock edge
//                i_waddr      write address
//                i_wdata      write data
//  Revision    : 1.0  initial release
// ============================================================================
module lbp_hist_bank
    import lbp_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [7:0]       i_raddr,
    output logic      [CNT_W-1:0] o_rdata,
    input  wire logic             i_we,
    input  wire logic [7:0]       i_waddr,
    input  wire logic [CNT_W-1:0] i_wdata
);

    logic [CNT_W-1:0]    r_bin [LBP_BINS];
    logic [LBP_BINS-1:0] r_touched;

    // Count storage carries no reset; validity comes from r_touched.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_bin[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_touched <= '0;
        end else if (i_we) begin
            r_touched[i_waddr] <= 1'b1;
        end
    end

    assign o_rdata = r_touched[i_raddr] ? r_bin[i_raddr] : '0;

endmodule : lbp_hist_bank
`default_nettype wire

// File: rtl/lbp_histogram.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_histogram
//  Description : Builds a 256-bin histogram of LBP codes from the engine's
//                result stream, then streams all bins out over a valid/ready
//                port once the engine raises finish.
//  Ports       : clk          single clock, rising edge
//                reset        asynchronous, active-high
//                bus (slave)  lbp_valid/lbp_data/finish in,
//                             hist_valid/hist_ready/hist_bin/hist_count dump,
//                             hist_done, pix_total, busy status
//  Revision    : 1.0  initial release
// ============================================================================
module lbp_histogram
    import lbp_pkg::*;
#(
    parameter int CNT_W = 14,
    parameter int TOT_W = 15
) (
    input  wire logic       clk,
    input  wire logic       reset,
    lbp_histogram_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] c_TOT_ONE = {{(TOT_W-1){1'b0}}, 1'b1};

    lbp_state_e       r_state;
    lbp_state_e       w_state_nxt;
    logic             r_finish_d;
    logic             r_s1_v;
    logic [7:0]       r_s1_code;
    logic             r_seen;
    logic [7:0]       r_ptr;
    logic             r_hist_valid;
    logic [7:0]       r_hist_bin;
    logic [CNT_W-1:0] r_hist_count;
    logic             r_hist_done;
    logic [TOT_W-1:0] r_pix_total;

    logic             w_fin_rise;
    logic             w_accept;
    logic             w_xfer;
    logic             w_last;
    logic [7:0]       w_raddr;
    logic [CNT_W-1:0] w_rdata;
    logic [CNT_W-1:0] w_wdata;

    assign w_fin_rise = bus.finish & ~r_finish_d;
    assign w_accept   = (r_state == ACC) & bus.lbp_valid;
    assign w_xfer     = r_hist_valid & bus.hist_ready;
    assign w_last     = w_xfer & (r_hist_bin == 8'hFF);

    // The read port serves S2 while accumulating and the pointer while
    // dumping; the two never overlap because S1 is empty once DUMP starts.
    assign w_raddr = (r_state == DUMP) ? r_ptr : r_s1_code;

    // Saturating increment; the write lands at the edge so an identical
    // code in the next cycle reads the updated value without forwarding.
    assign w_wdata = (&w_rdata) ? w_rdata : (w_rdata + c_CNT_ONE);

    lbp_hist_bank #(
        .CNT_W (CNT_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata),
        .i_we    (r_s1_v),
        .i_waddr (r_s1_code),
        .i_wdata (w_wdata)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ACC;
            r_finish_d <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_finish_d <= bus.finish;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_fin_rise) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DUMP;
            DUMP:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = ACC;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulate pipeline: S1 register, S2 total counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v      <= 1'b0;
            r_s1_code   <= 8'd0;
            r_seen      <= 1'b0;
            r_pix_total <= '0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_code <= bus.lbp_data;
                r_seen    <= 1'b1;
            end
            if (r_s1_v && !(&r_pix_total)) begin
                r_pix_total <= r_pix_total + c_TOT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dump port: load a new bin whenever the output slot is empty or the
    // current bin is being taken; the bin-255 transfer closes the stream.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= 8'd0;
            r_hist_valid <= 1'b0;
            r_hist_bin   <= 8'd0;
            r_hist_count <= '0;
            r_hist_done  <= 1'b0;
        end else if (r_state == DUMP) begin
            if (!r_hist_valid || bus.hist_ready) begin
                if (w_last) begin
                    r_hist_valid <= 1'b0;
                    r_hist_done  <= 1'b1;
                end else begin
                    r_hist_valid <= 1'b1;
                    r_hist_bin   <= r_ptr;
                    r_hist_count <= w_rdata;
                    r_ptr        <= r_ptr + 8'd1;
                end
            end
        end
    end

    assign bus.hist_valid = r_hist_valid;
    assign bus.hist_bin   = r_hist_bin;
    assign bus.hist_count = r_hist_count;
    assign bus.hist_done  = r_hist_done;
    assign bus.pix_total  = r_pix_total;
    assign bus.busy       = ((r_state == ACC) & r_seen) |
                            (r_state == DRAIN) | (r_state == DUMP);

endmodule : lbp_histogram
`default_nettype wire

// File: tb/tb_lbp_histogram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbp_histogram
//  Description : Two instances (CNT_W=14 and CNT_W=4) driven with identical
//                stimulus; a per-bin count model predicts every dumped bin.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lbp_histogram;
    import lbp_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lbp_histogram_if #(.CNT_W(14), .TOT_W(15)) bus14 ();
    lbp_histogram_if #(.CNT_W(4),  .TOT_W(15)) bus4  ();

    lbp_histogram #(.CNT_W(14), .TOT_W(15)) u_dut14 (.clk(clk), .reset(reset), .bus(bus14));
    lbp_histogram #(.CNT_W(4),  .TOT_W(15)) u_dut4  (.clk(clk), .reset(reset), .bus(bus4));

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_bins [256];
    int exp_total;
    bit fin_seen;
    bit checking = 1'b0;
    int exp_idx [2];
    bit stalled [2];
    int cap [2][256];
    int lim [2] = '{16383, 15};
    bit stopped;

    function automatic int sat(input int v, input int l);
        return (v > l) ? l : v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies one cycle of engine inputs to both instances; a pulse counts
    // if it arrives before or in the same cycle that finish first goes high.
    task automatic drive_cycle(input bit v, input logic [7:0] code, input bit fin);
        bus14.lbp_valid = v;    bus4.lbp_valid = v;
        bus14.lbp_data  = code; bus4.lbp_data  = code;
        bus14.finish    = fin;  bus4.finish    = fin;
        if (v && !fin_seen) begin
            exp_bins[code]++;
            exp_total++;
        end
        if (fin) fin_seen = 1'b1;
    endtask

    task automatic set_ready(input bit r);
        bus14.hist_ready = r;
        bus4.hist_ready  = r;
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_valid14"}, int'(bus14.hist_valid), 0);
        cmp({tag, "_bin14"},   int'(bus14.hist_bin),   0);
        cmp({tag, "_count14"}, int'(bus14.hist_count), 0);
        cmp({tag, "_done14"},  int'(bus14.hist_done),  0);
        cmp({tag, "_pix14"},   int'(bus14.pix_total),  0);
        cmp({tag, "_busy14"},  int'(bus14.busy),       0);
        cmp({tag, "_valid4"},  int'(bus4.hist_valid),  0);
        cmp({tag, "_count4"},  int'(bus4.hist_count),  0);
        cmp({tag, "_done4"},   int'(bus4.hist_done),   0);
        cmp({tag, "_pix4"},    int'(bus4.pix_total),   0);
    endtask

    task automatic do_reset(input bit fin);
        checking = 1'b0;
        reset    = 1'b1;
        bus14.lbp_valid = 1'b0; bus4.lbp_valid = 1'b0;
        bus14.lbp_data  = 8'd0; bus4.lbp_data  = 8'd0;
        bus14.finish    = fin;  bus4.finish    = fin;
        set_ready(1'b0);
        #1;
        check_zero("reset");
        repeat (3) step();
        for (int i = 0; i < 256; i++) begin
            exp_bins[i] = 0;
            cap[0][i]   = -1;
            cap[1][i]   = -1;
        end
        exp_total  = 0;
        fin_seen   = fin;  // cycle after release is the rise cycle, valid low
        exp_idx[0] = 0; exp_idx[1] = 0;
        stalled[0] = 1'b0; stalled[1] = 1'b0;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        drive_cycle(1'b0, 8'd0, fin_seen);
        repeat (n) step();
    endtask

    // Raises finish, keeps firing ignored pulses, randomises ready and waits
    // for both instances to deliver all 256 bins (or for bin stop_bin).
    task automatic dump(input int pct, input int stop_bin, output bit stop);
        stop     = 1'b0;
        checking = 1'b1;
        for (int cyc = 0; ; cyc++) begin
            if (exp_idx[0] >= 256 && exp_idx[1] >= 256) break;
            if (stop_bin >= 0 && exp_idx[0] == stop_bin) begin
                stop = 1'b1;
                break;
            end
            if (cyc > 3000) begin
                cmp("dump_timeout", exp_idx[0] + exp_idx[1], 512);
                break;
            end
            drive_cycle(($urandom % 4) == 0, 8'($urandom), 1'b1);
            set_ready(($urandom % 100) < pct);
            step();
        end
        if (!stop) begin
            checking = 1'b0;
            drive_cycle(1'b0, 8'd0, 1'b1);
            set_ready(1'b0);
            cmp("done14",  int'(bus14.hist_done),  1);
            cmp("done4",   int'(bus4.hist_done),   1);
            cmp("valid_end14", int'(bus14.hist_valid), 0);
            cmp("busy_end14",  int'(bus14.busy),       0);
            cmp("pix_total14", int'(bus14.pix_total), sat(exp_total, 32767));
            cmp("pix_total4",  int'(bus4.pix_total),  sat(exp_total, 32767));
        end
    endtask

    task automatic chk(input int w, input logic v, input logic [7:0] b,
                       input int c, input logic r, input logic bz);
        if (v) begin
            if (exp_idx[w] >= 256) begin
                cmp($sformatf("extra_bin[%0d]", w), int'(b), -1);
            end else begin
                cmp($sformatf("hist_bin[%0d]", w), int'(b), exp_idx[w]);
                cmp($sformatf("hist_count[%0d] bin %0d", w, b), c, sat(exp_bins[b], lim[w]));
                cmp($sformatf("busy_dump[%0d]", w), int'(bz), 1);
                if (r) begin
                    cap[w][b] = c;
                    exp_idx[w]++;
                end
            end
        end else if (stalled[w]) begin
            cmp($sformatf("valid_dropped_while_stalled[%0d]", w), 0, 1);
        end
        stalled[w] = v && !r;
    endtask

    always @(negedge clk) begin
        if (checking && !reset) begin
            chk(0, bus14.hist_valid, bus14.hist_bin, int'(bus14.hist_count),
                bus14.hist_ready, bus14.busy);
            chk(1, bus4.hist_valid, bus4.hist_bin, int'(bus4.hist_count),
                bus4.hist_ready, bus4.busy);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_cycle(1'b0, 8'd0, 1'b0);
        set_ready(1'b0);

        // 1: two separated pulses of 0x5A
        do_reset(1'b0);
        cmp("busy_idle", int'(bus14.busy), 0);
        drive_cycle(1'b1, 8'h5A, 1'b0); step();
        drive_cycle(1'b0, 8'd0, 1'b0);
        cmp("busy_after_pulse", int'(bus14.busy), 1);
        repeat (9) step();
        drive_cycle(1'b1, 8'h5A, 1'b0); step();
        idle(2);
        dump(100, -1, stopped);
        cmp("t1_bin5A", cap[0][8'h5A], 2);
        cmp("t1_bin00", cap[0][0], 0);
        cmp("t1_pix",   int'(bus14.pix_total), 2);

        // 2: back-to-back identical codes
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 8'h03, 1'b0); step();
        end
        idle(2);
        dump(100, -1, stopped);
        cmp("t2_bin03_14", cap[0][3], 3);
        cmp("t2_bin03_4",  cap[1][3], 3);
        cmp("t2_pix", int'(bus14.pix_total), 3);

        // 3: full image, code = index mod 256
        do_reset(1'b0);
        for (int i = 0; i < IMG_PIX_INT; i++) begin
            drive_cycle(1'b1, 8'(i % 256), 1'b0); step();
        end
        idle(2);
        dump(100, -1, stopped);
        cmp("t3_bin0",   cap[0][0],   63);
        cmp("t3_bin3",   cap[0][3],   63);
        cmp("t3_bin4",   cap[0][4],   62);
        cmp("t3_bin255", cap[0][255], 62);
        cmp("t3_sat4",   cap[1][0],   15);
        cmp("t3_pix", int'(bus14.pix_total), 15876);

        // 4: saturation in the narrow build
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 8'hFF, 1'b0); step();
        end
        idle(2);
        dump(100, -1, stopped);
        cmp("t4_bin255_4",  cap[1][255], 15);
        cmp("t4_bin255_14", cap[0][255], 20);
        cmp("t4_pix4", int'(bus4.pix_total), 20);

        // 5: random codes and gaps, 50% ready during dump
        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom % 100) < 70, 8'($urandom), 1'b0); step();
        end
        idle(2);
        dump(50, -1, stopped);

        // 6: reset in the middle of a dump, then a fresh run
        do_reset(1'b0);
        drive_cycle(1'b1, 8'h5A, 1'b0); step();
        idle(2);
        dump(100, 100, stopped);
        cmp("t6_reached_bin100", int'(stopped), 1);
        cmp("t6_bin100_shown", int'(bus14.hist_bin), 100);
        checking = 1'b0;
        reset = 1'b1;
        #1;
        check_zero("t6_async");
        do_reset(1'b0);
        drive_cycle(1'b1, 8'h10, 1'b0); step();
        idle(2);
        dump(100, -1, stopped);
        cmp("t6_bin10", cap[0][8'h10], 1);
        cmp("t6_bin5A", cap[0][8'h5A], 0);

        // 7: pulse together with finish rise counts, two cycles later not
        do_reset(1'b0);
        idle(2);
        drive_cycle(1'b1, 8'h77, 1'b1); step();
        drive_cycle(1'b0, 8'd0,  1'b1); step();
        drive_cycle(1'b1, 8'h88, 1'b1); step();
        dump(100, -1, stopped);
        cmp("t7_bin77", cap[0][8'h77], 1);
        cmp("t7_bin88", cap[0][8'h88], 0);
        cmp("t7_pix", int'(bus14.pix_total), 1);

        // 8: finish already high out of reset -> empty histogram
        do_reset(1'b1);
        dump(70, -1, stopped);
        cmp("t8_bin00", cap[0][0], 0);
        cmp("t8_pix", int'(bus14.pix_total), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_lbp_histogram
`default_nettype wire
